// File: rtl/io_map_pkg.sv
// Shared register-map constants for the memory-mapped switch/LED peripheral.
package io_map_pkg;

  localparam int unsigned OFF_SW_STATE    = 0;
  localparam int unsigned OFF_LED         = 1;
  localparam int unsigned OFF_SW_CHANGED  = 2;
  localparam int unsigned OFF_IRQ_MASK    = 3;
  localparam int unsigned IO_WINDOW_WORDS = 4;
  localparam int unsigned OFF_WIDTH       = $clog2(IO_WINDOW_WORDS);

endpackage

// File: rtl/mmio_switch_led_ports_if.sv
// Single-cycle CPU read/write bus used to reach the switch/LED register window.
interface mmio_switch_led_ports_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output addr, wr_en, rd_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  addr, wr_en, rd_en, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus whole-vector debounce; flags the edge on which a
// candidate has been stable long enough to be committed.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable_c,
  output logic             o_commit_c
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0]     r_sync1;
  logic [WIDTH-1:0]     r_sync2;
  logic [WIDTH-1:0]     r_cand;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_same;

  assign w_same = (r_sync2 == r_cand);

  // Commit fires on the edge where the counter steps onto DEBOUNCE_CYCLES; it
  // then saturates, so each stable candidate commits exactly once.
  assign o_commit_c = w_same && (r_cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));
  assign o_stable_c = r_cand;

  // Synchroniser, candidate capture and stability counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_same) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt < CNT_WIDTH'(DEBOUNCE_CYCLES)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_switch_led_ports.sv
// Memory-mapped switch/LED peripheral: bus decode, LED/mask registers,
// debounced switch state, sticky change flags and a maskable interrupt.
module mmio_switch_led_ports
  import io_map_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH      = 16,
  parameter int unsigned          DATA_WIDTH      = 16,
  parameter int unsigned          SW_WIDTH        = 16,
  parameter int unsigned          LED_WIDTH       = 16,
  parameter int unsigned          DEBOUNCE_CYCLES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 16'hFF00
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  mmio_switch_led_ports_if.slave bus,
  input  logic [SW_WIDTH-1:0]  i_switches,
  output logic [LED_WIDTH-1:0] o_leds,
  output logic                 o_irq
);

  logic [SW_WIDTH-1:0]   r_sw_state;
  logic [LED_WIDTH-1:0]  r_led;
  logic [SW_WIDTH-1:0]   r_changed;
  logic [SW_WIDTH-1:0]   r_mask;
  logic                  r_primed;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_irq;

  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_hit;
  logic [OFF_WIDTH-1:0]  w_sel;
  logic                  w_wr_led;
  logic                  w_wr_chg;
  logic                  w_wr_mask;
  logic [SW_WIDTH-1:0]   w_cand;
  logic                  w_commit;
  logic [SW_WIDTH-1:0]   w_set;
  logic [SW_WIDTH-1:0]   w_clr;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  switch_debouncer #(
    .WIDTH           (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_raw      (i_switches),
    .o_stable_c (w_cand),
    .o_commit_c (w_commit)
  );

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign w_off     = bus.addr - BASE_ADDR;
  assign w_hit     = (w_off < ADDR_WIDTH'(IO_WINDOW_WORDS));
  assign w_sel     = w_off[OFF_WIDTH-1:0];
  assign w_wr_led  = bus.wr_en && w_hit && (w_sel == OFF_WIDTH'(OFF_LED));
  assign w_wr_chg  = bus.wr_en && w_hit && (w_sel == OFF_WIDTH'(OFF_SW_CHANGED));
  assign w_wr_mask = bus.wr_en && w_hit && (w_sel == OFF_WIDTH'(OFF_IRQ_MASK));

  // First commit after reset only establishes the baseline, so no flags.
  assign w_set = (w_commit && r_primed) ? (w_cand ^ r_sw_state) : '0;
  assign w_clr = w_wr_chg ? bus.wr_data[SW_WIDTH-1:0] : '0;

  // Read mux from current register contents (pre-write on a same-cycle write).
  always_comb begin
    w_rd_mux = '0;
    if (w_hit) begin
      case (w_sel)
        OFF_WIDTH'(OFF_SW_STATE):   w_rd_mux = DATA_WIDTH'(r_sw_state);
        OFF_WIDTH'(OFF_LED):        w_rd_mux = DATA_WIDTH'(r_led);
        OFF_WIDTH'(OFF_SW_CHANGED): w_rd_mux = DATA_WIDTH'(r_changed);
        OFF_WIDTH'(OFF_IRQ_MASK):   w_rd_mux = DATA_WIDTH'(r_mask);
        default:                    w_rd_mux = '0;
      endcase
    end
  end

  // Register file, change flags (set beats clear), read port and interrupt.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sw_state <= '0;
      r_led      <= '0;
      r_changed  <= '0;
      r_mask     <= '0;
      r_primed   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_led)  r_led  <= bus.wr_data[LED_WIDTH-1:0];
      if (w_wr_mask) r_mask <= bus.wr_data[SW_WIDTH-1:0];
      r_changed <= (r_changed & ~w_clr) | w_set;
      if (w_commit) begin
        r_sw_state <= w_cand;
        r_primed   <= 1'b1;
      end
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= w_rd_mux;
      r_irq <= |(r_changed & r_mask);
    end
  end

  assign o_leds       = r_led;
  assign o_irq        = r_irq;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

endmodule
